stream_tx_ctrl: RTL and testbench
=================================

Name: stream_tx_ctrl

Overview:
- Transmitting end of the unit valid/ready stream protocol. Counterpart of the receive-side skid controller.
- Takes words from a unit's push interface and emits exactly `length` transfers on a registered valid/ready output, then pulses `done`.
- A 2-entry output buffer (main + skid) keeps every output and `push_ready` registered. No combinational path from `out_ready` to `push_ready`.

Parameters:
- DATA_W, 32, width of stream data.
- LEN_W, 16, width of the transfer-length configuration and internal counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- run  input  1  start pulse, sampled only in IDLE.
- length  input  LEN_W  number of transfers for this run, sampled with run.
- push  input  1  unit offers push_data this cycle.
- push_data  input  DATA_W  word offered by the unit.
- push_ready  output  1  registered; push is accepted when push && push_ready.
- out_valid  output  1  registered; buffer holds a word.
- out_data  output  DATA_W  registered; main buffer entry.
- out_ready  input  1  downstream accepts.
- out_transfer  output  1  out_valid && out_ready (combinational).
- busy  output  1  registered; high in RUN.
- done  output  1  registered; one-cycle pulse when a run completes.

Behaviour:
Reset (rst=1 at an edge), regardless of state:
- state=IDLE, occupancy=0, counters=0.
- push_ready=0, out_valid=0, busy=0, done=0, out_data=0.
- Mid-run reset discards buffered data and the run with no done pulse.

States:
- IDLE, run=1, length>0: latch length, clear accept_cnt and emit_cnt, go to RUN. busy=1 and push_ready=1 from the next cycle.
- IDLE, run=1, length=0: stay IDLE; done=1 next cycle for one cycle.
- RUN: run is ignored.
- RUN: on the edge where emit_cnt reaches length, go to IDLE. done=1 and busy=0 in the following cycle.

Accept side:
- accept = push && push_ready. Each accept increments accept_cnt.
- push_ready_next = (state_next==RUN) && (occ_next<2) && (accept_cnt_next<length).
- The unit may hold push high while push_ready=0; nothing is accepted.

Buffer (occ = occupancy, 0..2; accept and out_transfer are evaluated in the same cycle):
- occ0 + accept: main<=push_data, occ=1.
- occ1 + accept + transfer: main<=push_data, occ=1.
- occ1 + accept, no transfer: skid<=push_data, occ=2.
- occ1, no accept + transfer: occ=0.
- occ2 + transfer: main<=skid, occ=1. accept cannot occur in occ2 because push_ready=0.
- Any occupancy, no accept and no transfer: hold.

Output side:
- out_valid = (occ>0). out_data = main.
- While out_valid && !out_ready, out_valid and out_data must not change.
- Each out_transfer increments emit_cnt.
- Latency from accepted push to out_valid is 1 cycle. Sustained throughput is 1 word/cycle when out_ready=1.
- Ordering is strictly FIFO; no word is duplicated or dropped.
- Counter widths are LEN_W. length = 2^LEN_W-1 must work without wrap.

Decomposition:
- Shared package (stream_pkg): state encoding localparams ST_IDLE and ST_RUN, occupancy width constant.
- Sub-module stream_tx_buffer holds the 2-entry main/skid storage and occupancy logic. It has accept/transfer in and push_ready-eligible/out_valid/out_data out.
- stream_tx_ctrl owns the FSM, counters and done/busy.

Test Plan:
- Streaming: length=4, push held high, data 0xA0..0xA3, out_ready=1 → out_valid from the cycle after the first accept; 4 consecutive transfers 0xA0,0xA1,0xA2,0xA3; done pulses once; push_ready=0 after the 4th accept.
- Backpressure: length=3, out_ready=0 for 5 cycles after the first accept → occ reaches 2; push_ready drops; out_data stays 0xA0. After release, 0xA0,0xA1,0xA2 emerge in order with no loss.
- Alternating ready: out_ready toggling 1010…, length=8, random push gaps → exactly 8 transfers in FIFO order; out_data stable on every stalled cycle.
- Zero length: run with length=0 → busy stays 0; done=1 exactly one cycle later; no out_valid.
- Reset mid-run: rst asserted with occ=2 during a length=6 run → next cycle out_valid=0, push_ready=0, busy=0, no done. A new run with length=2 then completes normally.
- Ignored run: run pulsed while in RUN with length=5 → no restart; the original count completes; a single done pulse.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared encodings for the stream transmit controller and its output buffer.
package stream_pkg;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int OCC_W = 2;
  localparam logic [OCC_W-1:0] OCC_FULL = 2'd2;
endpackage

// File: rtl/stream_tx_buffer.sv
// Two-entry main/skid output buffer; accepted word is visible on out_data one cycle later.
// Backpressure: room_next is registered upstream; out_valid/out_data hold while stalled.
module stream_tx_buffer
  import stream_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              transfer,
  input  logic [DATA_W-1:0] push_data,
  output logic              room_next,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_next;
  logic [DATA_W-1:0] skid;

  always_comb begin
    occ_next = occ;
    case (occ)
      2'd0: if (accept) occ_next = 2'd1;
      2'd1: begin
        if (accept && !transfer)      occ_next = 2'd2;
        else if (!accept && transfer) occ_next = 2'd0;
      end
      2'd2: if (transfer) occ_next = 2'd1;
      default: occ_next = occ;
    endcase
    room_next = (occ_next < OCC_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid      <= '0;
    end else begin
      occ       <= occ_next;
      out_valid <= (occ_next != '0);
      // A word lands in main when main is empty or being drained this cycle.
      if (accept && (occ == 2'd0 || (occ == 2'd1 && transfer)))
        out_data <= push_data;
      else if (occ == 2'd2 && transfer)
        out_data <= skid;
      if (accept && occ == 2'd1 && !transfer)
        skid <= push_data;
    end
  end

endmodule

// File: rtl/stream_tx_ctrl.sv
// Emits exactly `length` words from the push interface, then pulses done; 1-cycle push-to-valid.
// Backpressure: push_ready is registered and drops when the 2-entry buffer would fill.
module stream_tx_ctrl
  import stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [LEN_W-1:0]  length,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_transfer,
  output logic              busy,
  output logic              done
);

  state_t           state_q, state_next;
  logic [LEN_W-1:0] len_q, len_next;
  logic [LEN_W-1:0] accept_cnt, accept_cnt_next;
  logic [LEN_W-1:0] emit_cnt, emit_cnt_next;
  logic             start, zero_run, accept, transfer, room_next;
  logic             push_ready_next, done_next;

  stream_tx_buffer #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .transfer  (transfer),
    .push_data (push_data),
    .room_next (room_next),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign out_transfer = transfer;

  always_comb begin
    start           = (state_q == ST_IDLE) && run && (length != '0);
    zero_run        = (state_q == ST_IDLE) && run && (length == '0);
    accept          = push && push_ready;
    transfer        = out_valid && out_ready;
    len_next        = start ? length : len_q;
    accept_cnt_next = start ? '0 : accept_cnt + {{(LEN_W-1){1'b0}}, accept};
    emit_cnt_next   = start ? '0 : emit_cnt + {{(LEN_W-1){1'b0}}, transfer};
    state_next      = state_q;
    if (start)
      state_next = ST_RUN;
    else if (state_q == ST_RUN && emit_cnt_next == len_q)
      state_next = ST_IDLE;
    push_ready_next = (state_next == ST_RUN) && room_next && (accept_cnt_next < len_next);
    done_next       = zero_run || (state_q == ST_RUN && state_next == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      accept_cnt <= '0;
      emit_cnt   <= '0;
      push_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_next;
      len_q      <= len_next;
      accept_cnt <= accept_cnt_next;
      emit_cnt   <= emit_cnt_next;
      push_ready <= push_ready_next;
      busy       <= (state_next == ST_RUN);
      done       <= done_next;
    end
  end

endmodule

// File: tb/tb_stream_tx_ctrl.sv
// Bench for stream_tx_ctrl: table of runs with a FIFO scoreboard, plus hand-written corner sequences.
module tb_stream_tx_ctrl;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [LEN_W-1:0]  length;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              out_transfer;
  logic              busy;
  logic              done;

  stream_tx_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .length       (length),
    .push         (push),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .out_transfer (out_transfer),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] sb[$];
  int run_acc  = 0;
  int run_xfer = 0;
  int done_cnt = 0;
  bit prev_stall = 0;
  logic [DATA_W-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: expected words enter on accept and are compared on transfer.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", out_data, prev_data);
      end
      check("out_transfer", {31'd0, out_transfer}, {31'd0, out_valid && out_ready});
      if (push && push_ready) begin
        sb.push_back(push_data);
        run_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", out_data, 32'hFFFF_FFFF);
        end else begin
          check("fifo_order", out_data, sb.pop_front());
        end
        run_xfer++;
      end
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  typedef struct {
    int          len;
    int          rmode;   // 0 always ready, 1 alternating, 2 random, 3 stalled for 6 cycles
    int          gmode;   // 0 push held high, 1 random gaps
    logic [31:0] base;
    bit          extra_run;
    int          exp_xfer;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic do_run(input vec_t v);
    int done_c;
    sb.delete();
    run_acc  = 0;
    run_xfer = 0;
    done_cnt = 0;
    done_c   = -1;
    @(posedge clk); #1;
    run = 1'b1; length = LEN_W'(v.len); push = 1'b0;
    @(posedge clk); #1;
    run = 1'b0;
    for (int c = 0; c < 400 && done_c < 0; c++) begin
      push      = (v.gmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      push_data = v.base + DATA_W'(run_acc);
      case (v.rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 2 == 0);
        2:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = (c >= 6);
      endcase
      if (v.extra_run && c == 2) begin
        run = 1'b1; length = LEN_W'(1);
      end else begin
        run = 1'b0;
      end
      @(negedge clk);
      if (v.rmode == 0 && v.gmode == 0 && c == 1) begin
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("first_data", out_data, v.base);
      end
      if (v.rmode == 3 && c == 4) begin
        check("bp_push_ready", {31'd0, push_ready}, 32'd0);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_data", out_data, v.base);
      end
      if (done) done_c = c;
      @(posedge clk); #1;
    end
    run = 1'b0; push = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("done_seen", {31'd0, done_c >= 0}, 32'd1);
    if (v.rmode == 0 && v.gmode == 0 && !v.extra_run)
      check("done_cycle", done_c, v.len + 1);
    check("xfer_count", run_xfer, v.exp_xfer);
    check("accept_count", run_acc, v.exp_xfer);
    check("done_count", done_cnt, v.exp_done);
    check("sb_empty", sb.size(), 0);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_push_ready", {31'd0, push_ready}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{len: 4, rmode: 0, gmode: 0, base: 32'hA0, extra_run: 0, exp_xfer: 4, exp_done: 1};
    vecs[1] = '{len: 3, rmode: 3, gmode: 0, base: 32'hA0, extra_run: 0, exp_xfer: 3, exp_done: 1};
    vecs[2] = '{len: 8, rmode: 1, gmode: 1, base: 32'h10, extra_run: 0, exp_xfer: 8, exp_done: 1};
    vecs[3] = '{len: 8, rmode: 2, gmode: 1, base: 32'h40, extra_run: 0, exp_xfer: 8, exp_done: 1};
    vecs[4] = '{len: 1, rmode: 0, gmode: 0, base: 32'h77, extra_run: 0, exp_xfer: 1, exp_done: 1};
    vecs[5] = '{len: 5, rmode: 1, gmode: 0, base: 32'h80, extra_run: 1, exp_xfer: 5, exp_done: 1};

    rst = 1'b1; run = 1'b0; length = '0; push = 1'b0; push_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_push_ready", {31'd0, push_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_run(vecs[i]);

    // Zero-length run: single done pulse, never busy.
    done_cnt = 0;
    @(posedge clk); #1;
    run = 1'b1; length = '0;
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    check("zl_done", {31'd0, done}, 32'd1);
    check("zl_busy", {31'd0, busy}, 32'd0);
    check("zl_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("zl_done_low", {31'd0, done}, 32'd0);
    check("zl_busy_low", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("zl_done_count", done_cnt, 1);

    // Reset mid-run with the buffer full.
    sb.delete(); run_acc = 0; done_cnt = 0;
    @(posedge clk); #1;
    run = 1'b1; length = LEN_W'(6); out_ready = 1'b0;
    @(posedge clk); #1;
    run = 1'b0; push = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push_data = 32'hC0 + DATA_W'(run_acc);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("mr_full_valid", {31'd0, out_valid}, 32'd1);
    check("mr_full_ready", {31'd0, push_ready}, 32'd0);
    check("mr_full_data", out_data, 32'hC0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; push = 1'b0; out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_push_ready", {31'd0, push_ready}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("mr_no_done", done_cnt, 0);
    do_run('{len: 2, rmode: 0, gmode: 0, base: 32'hD0, extra_run: 0, exp_xfer: 2, exp_done: 1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
